// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields (RR/IR/SR/LR) into RV32 words,
// buffers them in a small FIFO and streams them to instruction memory at
// consecutive word addresses. A seal request closes the program with a NOP.
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready              field tuple handshake
//   in_type, in_rd, in_r1, in_r2,
//   in_immediate, in_operation      decoded instruction fields
//   seal                            request terminator and finish
//   mem_write_en/ready/addr/data    instruction memory write port
//   error                           one-cycle pulse: immediate out of range
//   instr_count                     words written (incl. terminator)
//   done                            terminator written
//
// state  | meaning
// S_RUN  | accepting tuples, writing buffered words
// S_DRAIN| seal seen, flushing buffered words
// S_TERM | writing the NOP terminator
// S_DONE | program sealed, idle until reset
module instr_encoder #(
  parameter int ADDRESS_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int FIFO_DEPTH       = 4,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_type,
  input  logic [REG_ADDRESS_SIZE-1:0] in_rd,
  input  logic [REG_ADDRESS_SIZE-1:0] in_r1,
  input  logic [REG_ADDRESS_SIZE-1:0] in_r2,
  input  logic [ADDRESS_SIZE-1:0]     in_immediate,
  input  logic                        in_operation,
  input  logic                        seal,
  output logic                        mem_write_en,
  input  logic                        mem_write_ready,
  output logic [ADDRESS_SIZE-1:0]     mem_write_addr,
  output logic [ADDRESS_SIZE-1:0]     mem_write_data,
  output logic                        error,
  output logic [15:0]                 instr_count,
  output logic                        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] NOP_WORD = 'h13;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TERM, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDRESS_SIZE-1:0]   r_fifo [FIFO_DEPTH];
  logic [PW:0]               r_wptr, r_rptr;
  logic                      r_live;
  logic                      r_error;
  logic [ADDRESS_SIZE-1:0]   r_addr;
  logic [15:0]               r_count;

  logic                      w_empty, w_full;
  logic                      w_accept, w_push, w_pop, w_wr;
  logic                      w_range_ok;
  logic [ADDRESS_SIZE-1:0]   w_word;
  logic [ADDRESS_SIZE-12:0]  w_imm_hi;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  // r_live keeps in_ready low while reset is asserted (state alone would read RUN).
  assign in_ready = r_live && (r_state == S_RUN) && !w_full;
  assign w_accept = in_valid && in_ready;

  // Immediate must fit a 12-bit signed field: bits [MSB:11] all equal.
  assign w_imm_hi   = in_immediate[ADDRESS_SIZE-1:11];
  assign w_range_ok = (in_type == 2'd0) || (&w_imm_hi) || !(|w_imm_hi);
  assign w_push     = w_accept && w_range_ok;

  always_comb begin
    w_word = '0;
    unique case (in_type)
      2'd0: w_word = {1'b0, in_operation, 5'b0, in_r2[4:0], in_r1[4:0], 3'b000,
                      in_rd[4:0], 7'b0110011};
      2'd1: w_word = {in_immediate[11:0], in_r1[4:0], 3'b000, in_rd[4:0], 7'b0010011};
      2'd2: w_word = {in_immediate[11:5], in_r2[4:0], in_r1[4:0], 3'b010,
                      in_immediate[4:0], 7'b0100011};
      2'd3: w_word = {in_immediate[11:0], in_r1[4:0], 3'b010, in_rd[4:0], 7'b0000011};
    endcase
  end

  assign mem_write_en = ((r_state == S_RUN || r_state == S_DRAIN) && !w_empty) ||
                        (r_state == S_TERM);
  assign mem_write_data = (r_state == S_TERM) ? NOP_WORD :
                          (mem_write_en ? r_fifo[r_rptr[PW-1:0]] : '0);
  assign mem_write_addr = r_addr;
  assign w_wr  = mem_write_en && mem_write_ready;
  assign w_pop = w_wr && (r_state != S_TERM);

  assign error       = r_error;
  assign instr_count = r_count;
  assign done        = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (seal && r_live) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty)        w_state_nxt = S_TERM;
      S_TERM:  if (mem_write_ready) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_live  <= 1'b0;
      r_error <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_error <= w_accept && !w_range_ok;
      if (w_push) begin
        r_fifo[r_wptr[PW-1:0]] <= w_word;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr) begin
        r_addr  <= r_addr + ADDRESS_SIZE'(4);
        r_count <= r_count + 16'd1;
      end
    end
  end

endmodule
